axi_mem_slave: RTL and testbench
================================

// Module: axi_mem_slave
// PURPOSE
// - AXI4 slave memory model: consumes the master-side signal set of axi_if (slave view) and responds on all 5 channels.
// - Sits directly downstream of the master driver; the monitor taps the same bus. Serves as DUT stand-in / reference memory.
// - Independent write and read engines; one outstanding transaction per direction; FIXED/INCR/WRAP bursts up to 256 beats.
// PARAMETERS
// - ADDR_WIDTH  32    byte address width
// - DATA_WIDTH  32    data bus width (32/64/128)
// - ID_WIDTH    4     transaction ID width
// - STRB_WIDTH  DATA_WIDTH/8   byte strobes
// - MEM_DEPTH   1024  memory size in DATA_WIDTH words; word index = addr >> log2(STRB_WIDTH)
// PORTS
// - aclk                                  in   1    clock, all logic on rising edge
// - aresetn                               in   1    async active-low reset
// - awid/awaddr/awlen/awsize/awburst      in   ID/ADDR/8/3/2  write address
// - awlock/awcache/awprot/awqos/awregion  in   1/4/3/4/4      ignored (also ar* equivalents)
// - awvalid in 1 / awready out 1          AW handshake
// - wdata/wstrb/wlast/wvalid              in   DATA/STRB/1/1  write data; wready out 1
// - bid/bresp/bvalid                      out  ID/2/1         write response; bready in 1
// - arid/araddr/arlen/arsize/arburst      in   ID/ADDR/8/3/2  read address
// - arvalid in 1 / arready out 1          AR handshake
// - rid/rdata/rresp/rlast/rvalid          out  ID/DATA/2/1/1  read data; rready in 1
// BEHAVIOUR
// - Reset: all outputs 0 (awready, wready, bvalid, bid, bresp, arready, rvalid, rlast, rid, rdata, rresp); FSMs -> IDLE.
//   Memory array NOT reset. Reset mid-burst aborts: no B/R completes, FSMs IDLE, partial writes remain.
// - awready/arready rise 1st cycle after aresetn deasserts (IDLE is registered-ready).
// - Write FSM: W_IDLE (awready=1) --AW hs--> W_DATA (wready=1) --last beat hs--> W_RESP (bvalid=1) --bready--> W_IDLE.
//   AW hs latches id/addr/len/size/burst, beat_cnt=0. Each W hs: bytes with wstrb=1 written, beat_cnt++, addr advances.
//   Last beat = beat_cnt==len (counter governs, not wlast). bvalid 1 cycle after last W hs; bid=latched id.
//   bvalid/bid/bresp held stable until bready; back-to-back: awready=1 on cycle after B hs.
// - Read FSM: R_IDLE (arready=1) --AR hs--> R_DATA --last beat hs--> R_IDLE.
//   rvalid first asserts cycle after AR hs (rdata registered from mem at hs). On each R hs with more beats, next
//   word loaded same edge -> 1 beat/cycle with rready held high. rlast=1 iff beat_cnt==len. rid=latched id.
//   rdata/rresp/rlast held stable while rvalid && !rready.
// - Address gen (per beat, bytes): FIXED: addr unchanged. INCR: addr=(addr & ~(2^size-1)) + 2^size.
//   WRAP: wrap_bytes=(len+1)<<size; next=addr+2^size; if next crosses aligned wrap boundary, wrap to boundary base.
//   Arithmetic modulo 2^ADDR_WIDTH; no 4KB check.
// - Error -> SLVERR (2'b10), else OKAY (2'b00); no EXOKAY/DECERR:
//   word index >= MEM_DEPTH (that beat: write suppressed / rdata=0, rresp=SLVERR per beat);
//   size > log2(STRB_WIDTH) (all beats suppressed); WRAP with len not in {1,3,7,15}; burst==2'b11 (reserved);
//   wlast value != (beat_cnt==len) on any W beat. bresp = OR of errors over whole burst (sticky).
// - Concurrent read/write same word same cycle: read returns old data (read-before-write).
// - Narrow transfers: write strobes used as given; read returns full word.
// STRUCTURE
// - axi_pkg: burst_t enum {FIXED=0,INCR=1,WRAP=2}, RESP_OKAY/RESP_SLVERR constants, w_state_t, r_state_t.
// - Sub-module axi_burst_addr_gen (comb: addr,size,len,burst -> next_addr, illegal); instanced twice (W and R).
// - Memory: logic [DATA_WIDTH-1:0] mem[MEM_DEPTH], byte-lane write loop.
// TESTING
// - INCR write len=3 size=2 addr 0x10 data A0..A3 strb F -> bresp=0,bid=awid; INCR read same -> A0..A3, rlast on 4th.
// - WRAP read len=3 size=2 araddr 0x38 -> word addrs 0x38,0x3C,0x30,0x34; FIXED write len=1 -> only last data at addr.
// - Write strb=4'b0101 data 0xAABBCCDD over 0x11223344 -> readback 0x11BB33DD.
// - awaddr=MEM_DEPTH*4 len=0 -> bresp=2'b10, memory unchanged; araddr same -> rresp=2'b10, rdata=0.
// - rready low 5 cycles mid-burst -> rvalid/rdata/rlast stable; bready low 3 cycles -> bvalid/bresp held.
// - aresetn pulsed during W_DATA beat 2 of 4 -> all outputs 0 async; awready=1 cycle after release; next txn OK.

Source files
------------

// File: rtl/axi_mem_slave_pkg.sv
// Shared types and constants for the AXI4 slave memory model.
// Imported by the address generator and the top-level slave.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  // Wrapping bursts only make sense for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_mem_slave_if.sv
// AXI4 bus bundle shared by the master driver, the monitor and the slave memory.
// The slave view omits the lock/cache/prot/qos/region sidebands because it ignores them.
interface axi_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic [3:0]            awqos;
  logic [3:0]            awregion;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic [3:0]            arqos;
  logic [3:0]            arregion;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

endinterface

// File: rtl/axi_mem_slave_addr_gen.sv
// Combinational per-beat AXI address stepper for FIXED/INCR/WRAP bursts.
// Also flags burst parameters the slave refuses to serve.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = 4
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  illegal
);

  localparam int SIZE_MAX = $clog2(STRB_WIDTH);

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] aligned;
  logic [ADDR_WIDTH-1:0] stepped;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] wrap_base;

  // Wrap window is (len+1) transfers wide and aligned to its own size.
  always_comb begin
    incr      = ADDR_WIDTH'(1) << size;
    aligned   = addr & ~(incr - ADDR_WIDTH'(1));
    stepped   = aligned + incr;
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    wrap_base = addr & ~wrap_mask;
    next_addr = addr;
    case (burst)
      FIXED:   next_addr = addr;
      INCR:    next_addr = stepped;
      WRAP:    next_addr = ((stepped & ~wrap_mask) != wrap_base) ? wrap_base : stepped;
      default: next_addr = addr;
    endcase
    illegal = (int'(size) > SIZE_MAX) || (burst == 2'b11) ||
              ((burst == WRAP) && !wrap_len_ok(len));
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 slave memory model with independent write and read engines,
// one outstanding burst per direction, and SLVERR reporting for bad accesses.
module axi_mem_slave
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_DEPTH  = 1024
) (
  input logic  aclk,
  input logic  aresetn,
  axi_if.slave s
);

  localparam int OFFS   = $clog2(STRB_WIDTH);
  localparam int MEM_AW = $clog2(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  w_state_t              w_state, w_next;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err;
  logic                  awready_q, wready_q, bvalid_q;
  logic                  awready_d, wready_d, bvalid_d;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [1:0]            bresp_q;
  logic                  aw_hs, w_hs, b_hs, w_last_beat;
  logic [ADDR_WIDTH-1:0] w_next_addr, w_idx;
  logic                  w_illegal, w_oob, w_beat_err, w_do_write;

  r_state_t              r_state, r_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  arready_q, rvalid_q, rlast_q;
  logic                  arready_d, rvalid_d;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  ar_hs, r_hs, r_last_beat, r_load;
  logic [ADDR_WIDTH-1:0] g_addr, r_gen_next, r_load_addr, r_idx;
  logic [2:0]            g_size;
  logic [7:0]            g_len;
  logic [1:0]            g_burst;
  logic                  r_illegal, r_oob;

  assign s.awready = awready_q;
  assign s.wready  = wready_q;
  assign s.bvalid  = bvalid_q;
  assign s.bid     = bid_q;
  assign s.bresp   = bresp_q;
  assign s.arready = arready_q;
  assign s.rvalid  = rvalid_q;
  assign s.rlast   = rlast_q;
  assign s.rid     = rid_q;
  assign s.rdata   = rdata_q;
  assign s.rresp   = rresp_q;

  assign aw_hs       = s.awvalid & awready_q;
  assign w_hs        = s.wvalid & wready_q;
  assign b_hs        = bvalid_q & s.bready;
  assign w_last_beat = (w_cnt == w_len);
  assign w_idx       = w_addr >> OFFS;
  assign w_oob       = (w_idx >= ADDR_WIDTH'(MEM_DEPTH));
  // The beat counter decides the end of burst; a disagreeing wlast only marks an error.
  assign w_beat_err  = w_illegal | w_oob | (s.wlast != w_last_beat);
  assign w_do_write  = w_hs & ~w_illegal & ~w_oob;

  axi_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .STRB_WIDTH(STRB_WIDTH)
  ) u_wgen (
    .addr     (w_addr),
    .size     (w_size),
    .len      (w_len),
    .burst    (w_burst),
    .next_addr(w_next_addr),
    .illegal  (w_illegal)
  );

  // Handshake outputs are registered from the next state so they are clean after reset.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
    awready_d = (w_next == W_IDLE);
    wready_d  = (w_next == W_DATA);
    bvalid_d  = (w_next == W_RESP);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      w_id      <= '0;
      w_addr    <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_size    <= '0;
      w_burst   <= '0;
      w_err     <= 1'b0;
    end else begin
      w_state   <= w_next;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      if (aw_hs) begin
        w_id    <= s.awid;
        w_addr  <= s.awaddr;
        w_len   <= s.awlen;
        w_size  <= s.awsize;
        w_burst <= s.awburst;
        w_cnt   <= '0;
        w_err   <= 1'b0;
      end
      if (w_hs) begin
        w_cnt  <= w_cnt + 8'd1;
        w_addr <= w_next_addr;
        w_err  <= w_err | w_beat_err;
        if (w_last_beat) begin
          bid_q   <= w_id;
          bresp_q <= (w_err | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (w_do_write) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s.wstrb[b]) mem[w_idx[MEM_AW-1:0]][8*b +: 8] <= s.wdata[8*b +: 8];
      end
    end
  end

  assign ar_hs       = s.arvalid & arready_q;
  assign r_hs        = rvalid_q & s.rready;
  assign r_last_beat = (r_cnt == r_len);
  assign r_load      = ar_hs | (r_hs & ~r_last_beat);

  // In idle the generator checks the incoming request; mid-burst it steps the latched one.
  always_comb begin
    if (r_state == R_IDLE) begin
      g_addr      = s.araddr;
      g_size      = s.arsize;
      g_len       = s.arlen;
      g_burst     = s.arburst;
      r_load_addr = s.araddr;
    end else begin
      g_addr      = r_addr;
      g_size      = r_size;
      g_len       = r_len;
      g_burst     = r_burst;
      r_load_addr = r_gen_next;
    end
  end

  assign r_idx = r_load_addr >> OFFS;
  assign r_oob = (r_idx >= ADDR_WIDTH'(MEM_DEPTH));

  axi_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .STRB_WIDTH(STRB_WIDTH)
  ) u_rgen (
    .addr     (g_addr),
    .size     (g_size),
    .len      (g_len),
    .burst    (g_burst),
    .next_addr(r_gen_next),
    .illegal  (r_illegal)
  );

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: if (ar_hs) r_next = R_DATA;
      R_DATA: if (r_hs && r_last_beat) r_next = R_IDLE;
    endcase
    arready_d = (r_next == R_IDLE);
    rvalid_d  = (r_next == R_DATA);
  end

  // Memory is sampled on the load edge, so a same-cycle write to that word is not yet visible.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
    end else begin
      r_state   <= r_next;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      if (ar_hs) begin
        rid_q   <= s.arid;
        r_len   <= s.arlen;
        r_size  <= s.arsize;
        r_burst <= s.arburst;
        r_cnt   <= '0;
        rlast_q <= (s.arlen == 8'd0);
      end else if (r_hs) begin
        r_cnt   <= r_cnt + 8'd1;
        rlast_q <= !r_last_beat && ((r_cnt + 8'd1) == r_len);
      end
      if (r_load) begin
        r_addr  <= r_load_addr;
        rdata_q <= (r_illegal | r_oob) ? '0 : mem[r_idx[MEM_AW-1:0]];
        rresp_q <= (r_illegal | r_oob) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed self-checking bench for axi_mem_slave: bursts, strobes, errors,
// back-pressure on B and R, and reset in the middle of a write burst.
module tb_axi_mem_slave;
  import axi_pkg::*;

  logic aclk;
  logic aresetn;
  int   checks;
  int   errors;

  logic [31:0] wbuf  [16];
  logic [31:0] rbuf  [16];
  logic [1:0]  rrbuf [16];
  logic        rlbuf [16];
  logic [3:0]  ridbuf[16];
  logic [1:0]  b_resp;
  logic [3:0]  b_id;

  axi_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

  axi_mem_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .ID_WIDTH  (4),
    .MEM_DEPTH (1024)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .s      (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic init_bus();
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awlock = 1'b0; bus.awcache = '0; bus.awprot = '0; bus.awqos = '0; bus.awregion = '0;
    bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arlock = 1'b0; bus.arcache = '0; bus.arprot = '0; bus.arqos = '0; bus.arregion = '0;
    bus.arvalid = 1'b0;
    bus.rready = 1'b0;
  endtask

  task automatic send_aw(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [3:0] id);
    int n;
    bus.awaddr = addr; bus.awlen = len; bus.awsize = 3'd2; bus.awburst = burst; bus.awid = id;
    bus.awvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!bus.awready && n < 50);
    if (!bus.awready) begin
      checks++; errors++;
      $display("[TB] FAIL aw_timeout: awready=%0b required 1", bus.awready);
    end
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input int nbeats, input int last_idx, input logic [3:0] strb);
    int n;
    for (int i = 0; i < nbeats; i++) begin
      bus.wdata = wbuf[i]; bus.wstrb = strb; bus.wlast = (i == last_idx); bus.wvalid = 1'b1;
      n = 0;
      do begin @(negedge aclk); n++; end while (!bus.wready && n < 50);
      if (!bus.wready) begin
        checks++; errors++;
        $display("[TB] FAIL w_timeout: wready=%0b required 1 (beat %0d)", bus.wready, i);
      end
      @(posedge aclk); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic get_b();
    int n;
    bus.bready = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!bus.bvalid && n < 50);
    if (!bus.bvalid) begin
      checks++; errors++;
      $display("[TB] FAIL b_timeout: bvalid=%0b required 1", bus.bvalid);
    end
    b_resp = bus.bresp; b_id = bus.bid;
    @(posedge aclk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [3:0] id);
    int n;
    bus.araddr = addr; bus.arlen = len; bus.arsize = 3'd2; bus.arburst = burst; bus.arid = id;
    bus.arvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!bus.arready && n < 50);
    if (!bus.arready) begin
      checks++; errors++;
      $display("[TB] FAIL ar_timeout: arready=%0b required 1", bus.arready);
    end
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic get_r(input int nbeats);
    int n;
    bus.rready = 1'b1;
    for (int i = 0; i < nbeats; i++) begin
      n = 0;
      do begin @(negedge aclk); n++; end while (!bus.rvalid && n < 50);
      if (!bus.rvalid) begin
        checks++; errors++;
        $display("[TB] FAIL r_timeout: rvalid=%0b required 1 (beat %0d)", bus.rvalid, i);
      end
      rbuf[i] = bus.rdata; rrbuf[i] = bus.rresp; rlbuf[i] = bus.rlast; ridbuf[i] = bus.rid;
      @(posedge aclk); #1;
    end
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    init_bus();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.bid, bus.bresp, bus.arready, bus.rvalid,
         bus.rlast, bus.rid, bus.rdata, bus.rresp} !== 50'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: aw=%0b w=%0b b=%0b ar=%0b r=%0b rdata=%h required all 0",
               bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rdata);
    end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if (bus.awready !== 1'b0) begin
      errors++; $display("[TB] FAIL awready_before_edge: got %0b required 0", bus.awready);
    end
    @(negedge aclk);
    checks++;
    if ({bus.awready, bus.arready} !== 2'b11) begin
      errors++; $display("[TB] FAIL ready_after_reset: got %b required 11", {bus.awready, bus.arready});
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_incr_write();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h0000_00A0 + i;
    send_aw(32'h10, 8'd3, INCR, 4'd5);
    send_w(4, 3, 4'hF);
    get_b();
    checks++;
    if (b_resp !== RESP_OKAY || b_id !== 4'd5) begin
      errors++; $display("[TB] FAIL incr_write_b: bresp=%b bid=%0d required 00 / 5", b_resp, b_id);
    end
  endtask

  task automatic test_incr_read();
    send_ar(32'h10, 8'd3, INCR, 4'd3);
    get_r(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rbuf[i] !== 32'h0000_00A0 + i || rrbuf[i] !== RESP_OKAY || ridbuf[i] !== 4'd3 ||
          rlbuf[i] !== (i == 3)) begin
        errors++;
        $display("[TB] FAIL incr_read beat %0d: data=%h resp=%b id=%0d last=%0b required %h/00/3/%0b",
                 i, rbuf[i], rrbuf[i], ridbuf[i], rlbuf[i], 32'h0000_00A0 + i, (i == 3));
      end
    end
  endtask

  task automatic test_wrap_read();
    logic [31:0] exp [4];
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hC000_0030 + 4 * i;
    send_aw(32'h30, 8'd3, INCR, 4'd1);
    send_w(4, 3, 4'hF);
    get_b();
    exp[0] = 32'hC000_0038; exp[1] = 32'hC000_003C; exp[2] = 32'hC000_0030; exp[3] = 32'hC000_0034;
    send_ar(32'h38, 8'd3, WRAP, 4'd2);
    get_r(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rbuf[i] !== exp[i] || rrbuf[i] !== RESP_OKAY) begin
        errors++;
        $display("[TB] FAIL wrap_read beat %0d: data=%h resp=%b required %h/00", i, rbuf[i], rrbuf[i], exp[i]);
      end
    end
  endtask

  task automatic test_fixed_write();
    wbuf[0] = 32'h1111_1111; wbuf[1] = 32'h2222_2222;
    send_aw(32'h50, 8'd1, FIXED, 4'd7);
    send_w(2, 1, 4'hF);
    get_b();
    send_ar(32'h50, 8'd0, INCR, 4'd0);
    get_r(1);
    checks++;
    if (b_resp !== RESP_OKAY || rbuf[0] !== 32'h2222_2222 || rlbuf[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fixed_write: bresp=%b data=%h last=%0b required 00/22222222/1", b_resp, rbuf[0], rlbuf[0]);
    end
  endtask

  task automatic test_strobe();
    wbuf[0] = 32'h1122_3344;
    send_aw(32'h60, 8'd0, INCR, 4'd0);
    send_w(1, 0, 4'hF);
    get_b();
    wbuf[0] = 32'hAABB_CCDD;
    send_aw(32'h60, 8'd0, INCR, 4'd0);
    send_w(1, 0, 4'b0101);
    get_b();
    send_ar(32'h60, 8'd0, INCR, 4'd0);
    get_r(1);
    checks++;
    if (rbuf[0] !== 32'h11BB_33DD) begin
      errors++; $display("[TB] FAIL strobe_merge: got %h required 11bb33dd", rbuf[0]);
    end
  endtask

  task automatic test_out_of_range();
    wbuf[0] = 32'hCAFE_F00D;
    send_aw(32'h0, 8'd0, INCR, 4'd0);
    send_w(1, 0, 4'hF);
    get_b();
    wbuf[0] = 32'hDEAD_BEEF;
    send_aw(32'd4096, 8'd0, INCR, 4'd4);
    send_w(1, 0, 4'hF);
    get_b();
    checks++;
    if (b_resp !== RESP_SLVERR || b_id !== 4'd4) begin
      errors++; $display("[TB] FAIL oob_write_b: bresp=%b bid=%0d required 10 / 4", b_resp, b_id);
    end
    send_ar(32'h0, 8'd0, INCR, 4'd0);
    get_r(1);
    checks++;
    if (rbuf[0] !== 32'hCAFE_F00D) begin
      errors++; $display("[TB] FAIL oob_mem_unchanged: got %h required cafef00d", rbuf[0]);
    end
    send_ar(32'd4096, 8'd0, INCR, 4'd8);
    get_r(1);
    checks++;
    if (rbuf[0] !== 32'h0 || rrbuf[0] !== RESP_SLVERR || rlbuf[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL oob_read: data=%h resp=%b last=%0b required 0/10/1", rbuf[0], rrbuf[0], rlbuf[0]);
    end
  endtask

  task automatic test_bready_stall();
    wbuf[0] = 32'h7777_7777;
    send_aw(32'h70, 8'd0, INCR, 4'd9);
    send_w(1, 0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      checks++;
      if (bus.bvalid !== 1'b1 || bus.bresp !== RESP_OKAY || bus.bid !== 4'd9) begin
        errors++;
        $display("[TB] FAIL b_hold cycle %0d: bvalid=%0b bresp=%b bid=%0d required 1/00/9",
                 i, bus.bvalid, bus.bresp, bus.bid);
      end
    end
    @(posedge aclk); #1;
    get_b();
  endtask

  task automatic test_rready_stall();
    logic [31:0] held;
    send_ar(32'h10, 8'd3, INCR, 4'd6);
    get_r(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      held = bus.rdata;
      checks++;
      if (bus.rvalid !== 1'b1 || held !== 32'h0000_00A1 || bus.rlast !== 1'b0 || bus.rresp !== RESP_OKAY) begin
        errors++;
        $display("[TB] FAIL r_hold cycle %0d: rvalid=%0b rdata=%h rlast=%0b required 1/000000a1/0",
                 i, bus.rvalid, held, bus.rlast);
      end
    end
    @(posedge aclk); #1;
    get_r(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rbuf[i] !== 32'h0000_00A1 + i || rlbuf[i] !== (i == 2) || ridbuf[i] !== 4'd6) begin
        errors++;
        $display("[TB] FAIL r_resume beat %0d: data=%h last=%0b id=%0d required %h/%0b/6",
                 i, rbuf[i], rlbuf[i], ridbuf[i], 32'h0000_00A1 + i, (i == 2));
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hB000_0000 + i;
    send_aw(32'h80, 8'd3, INCR, 4'd2);
    send_w(2, 3, 4'hF);
    bus.wdata = wbuf[2]; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    #2;
    aresetn = 1'b0;
    #1;
    checks++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.bid, bus.bresp, bus.arready, bus.rvalid,
         bus.rlast, bus.rid, bus.rdata, bus.rresp} !== 50'd0) begin
      errors++;
      $display("[TB] FAIL async_reset_outputs: aw=%0b w=%0b b=%0b ar=%0b r=%0b required all 0",
               bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid);
    end
    bus.wvalid = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    checks++;
    if (bus.awready !== 1'b1 || bus.bvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL ready_after_pulse: awready=%0b bvalid=%0b required 1/0", bus.awready, bus.bvalid);
    end
    @(posedge aclk); #1;
    send_ar(32'h80, 8'd1, INCR, 4'd0);
    get_r(2);
    checks++;
    if (rbuf[0] !== 32'hB000_0000 || rbuf[1] !== 32'hB000_0001) begin
      errors++; $display("[TB] FAIL partial_write_kept: got %h %h required b0000000 b0000001", rbuf[0], rbuf[1]);
    end
    wbuf[0] = 32'h9090_9090;
    send_aw(32'h90, 8'd0, INCR, 4'd3);
    send_w(1, 0, 4'hF);
    get_b();
    send_ar(32'h90, 8'd0, INCR, 4'd0);
    get_r(1);
    checks++;
    if (b_resp !== RESP_OKAY || b_id !== 4'd3 || rbuf[0] !== 32'h9090_9090) begin
      errors++;
      $display("[TB] FAIL txn_after_reset: bresp=%b bid=%0d data=%h required 00/3/90909090", b_resp, b_id, rbuf[0]);
    end
  endtask

  task automatic test_back_to_back();
    wbuf[0] = 32'h0A0A_0A0A;
    send_aw(32'hA0, 8'd0, INCR, 4'd1);
    send_w(1, 0, 4'hF);
    get_b();
    @(negedge aclk);
    checks++;
    if (bus.awready !== 1'b1) begin
      errors++; $display("[TB] FAIL awready_after_b: got %0b required 1", bus.awready);
    end
    @(posedge aclk); #1;
    wbuf[0] = 32'h0B0B_0B0B;
    send_aw(32'hA4, 8'd0, INCR, 4'd2);
    send_w(1, 0, 4'hF);
    get_b();
    send_ar(32'hA0, 8'd1, INCR, 4'd0);
    get_r(2);
    checks++;
    if (b_id !== 4'd2 || rbuf[0] !== 32'h0A0A_0A0A || rbuf[1] !== 32'h0B0B_0B0B) begin
      errors++;
      $display("[TB] FAIL back_to_back: bid=%0d data=%h %h required 2/0a0a0a0a/0b0b0b0b", b_id, rbuf[0], rbuf[1]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_incr_write();
    test_incr_read();
    test_wrap_read();
    test_fixed_write();
    test_strobe();
    test_out_of_range();
    test_bready_stall();
    test_rready_stall();
    test_reset_mid_burst();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
